// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - RISC-V write-back stage: result select, load extension, RF write (WB_RETIRE_CNT_EN adds retire_count)
// Optional: define WB_RETIRE_CNT_EN to add the 64-bit retired-instruction counter.
module wb_stage #(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       result_src,
    input  logic [2:0]       load_sel,
    input  logic             reg_write,
    input  logic [RF_AW-1:0] rd_addr,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  pc_plus4,
    input  logic [XLEN-1:0]  lui_pc,
    input  logic             load_valid,
    input  logic [XLEN-1:0]  load_data,
`ifdef WB_RETIRE_CNT_EN
    output logic [63:0]      retire_count,
`endif
    output logic             rf_we,
    output logic [RF_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             wb_busy
);

    typedef enum logic [1:0] {IDLE, WAIT_LOAD, WRITE} state_t;

    state_t            state_q, state_d;
    logic              pending_q, pending_d;
    logic [1:0]        src_q, src_d;
    logic [2:0]        sel_q, sel_d;
    logic              we_q, we_d;
    logic [RF_AW-1:0]  rd_q, rd_d;
    logic [XLEN-1:0]   alu_q, alu_d;
    logic [XLEN-1:0]   pc4_q, pc4_d;
    logic [XLEN-1:0]   lui_q, lui_d;
    logic [XLEN-1:0]   ldata_q, ldata_d;

    logic              accept;
    logic [2:0]        off;
    logic [XLEN-1:0]   shifted_b, shifted_h, shifted_w;
    logic [XLEN-1:0]   load_ext;
    logic [XLEN-1:0]   wdata_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            src_q     <= '0;
            sel_q     <= '0;
            we_q      <= 1'b0;
            rd_q      <= '0;
            alu_q     <= '0;
            pc4_q     <= '0;
            lui_q     <= '0;
            ldata_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            src_q     <= src_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            rd_q      <= rd_d;
            alu_q     <= alu_d;
            pc4_q     <= pc4_d;
            lui_q     <= lui_d;
            ldata_q   <= ldata_d;
        end
    end

    assign in_ready = (state_q != WAIT_LOAD);
    assign wb_busy  = (state_q == WAIT_LOAD);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        src_d     = src_q;
        sel_d     = sel_q;
        we_d      = we_q;
        rd_d      = rd_q;
        alu_d     = alu_q;
        pc4_d     = pc4_q;
        lui_d     = lui_q;
        ldata_d   = ldata_q;
        case (state_q)
            WAIT_LOAD: begin
                // A response that arrived with the accept is parked in pending_q.
                if (pending_q) begin
                    pending_d = 1'b0;
                    state_d   = WRITE;
                end else if (load_valid) begin
                    ldata_d = load_data;
                    state_d = WRITE;
                end
            end
            default: begin
                if (accept) begin
                    src_d = result_src;
                    sel_d = load_sel;
                    we_d  = reg_write;
                    rd_d  = rd_addr;
                    alu_d = alu_result;
                    pc4_d = pc_plus4;
                    lui_d = lui_pc;
                    if (result_src == 2'b01) begin
                        state_d   = WAIT_LOAD;
                        pending_d = load_valid;
                        if (load_valid) ldata_d = load_data;
                    end else begin
                        state_d = WRITE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        off       = (XLEN == 64) ? alu_q[2:0] : {1'b0, alu_q[1:0]};
        shifted_b = ldata_q >> {off, 3'b000};
        shifted_h = ldata_q >> {off[2:1], 4'b0000};
        shifted_w = ldata_q >> {off[2], 5'b00000};
        case (sel_q)
            3'b000:  load_ext = XLEN'($signed(shifted_b[7:0]));
            3'b100:  load_ext = XLEN'(shifted_b[7:0]);
            3'b001:  load_ext = XLEN'($signed(shifted_h[15:0]));
            3'b101:  load_ext = XLEN'(shifted_h[15:0]);
            3'b010:  load_ext = XLEN'($signed(shifted_w[31:0]));
            3'b011:  load_ext = (XLEN == 64) ? ldata_q : XLEN'(shifted_w[31:0]);
            default: load_ext = XLEN'(shifted_w[31:0]);
        endcase
        case (src_q)
            2'b00:   wdata_sel = alu_q;
            2'b01:   wdata_sel = load_ext;
            2'b10:   wdata_sel = pc4_q;
            default: wdata_sel = lui_q;
        endcase
    end

    assign rf_we    = (state_q == WRITE) && we_q && (rd_q != '0);
    assign rf_waddr = rf_we ? rd_q : '0;
    assign rf_wdata = rf_we ? wdata_sel : '0;

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_count_q, retire_count_d;

    // Counts every instruction passing through WRITE, including suppressed x0 writes.
    always_comb begin
        retire_count_d = retire_count_q;
        if (state_q == WRITE) retire_count_d = retire_count_q + 64'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) retire_count_q <= '0;
        else      retire_count_q <= retire_count_d;
    end

    assign retire_count = retire_count_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - directed self-checking bench for wb_stage (XLEN=32)
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  result_src;
    logic [2:0]  load_sel;
    logic        reg_write;
    logic [4:0]  rd_addr;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] lui_pc;
    logic        load_valid;
    logic [31:0] load_data;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        wb_busy;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_count;
`endif

    int n_tests;
    int n_fail;

    wb_stage #(.XLEN(32), .RF_AW(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .result_src (result_src),
        .load_sel   (load_sel),
        .reg_write  (reg_write),
        .rd_addr    (rd_addr),
        .alu_result (alu_result),
        .pc_plus4   (pc_plus4),
        .lui_pc     (lui_pc),
        .load_valid (load_valid),
        .load_data  (load_data),
`ifdef WB_RETIRE_CNT_EN
        .retire_count (retire_count),
`endif
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .wb_busy    (wb_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] src, input logic [2:0] sel, input logic rw,
                         input logic [4:0] rd, input logic [31:0] alu);
        in_valid   = 1'b1;
        result_src = src;
        load_sel   = sel;
        reg_write  = rw;
        rd_addr    = rd;
        alu_result = alu;
    endtask

    task automatic check_write(input string tag, input logic [4:0] rd, input logic [31:0] data);
        check({tag, ".we"},    64'(rf_we),    64'd1);
        check({tag, ".waddr"}, 64'(rf_waddr), 64'(rd));
        check({tag, ".wdata"}, 64'(rf_wdata), 64'(data));
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        result_src = 2'b00;
        load_sel   = 3'b000;
        reg_write  = 1'b0;
        rd_addr    = 5'd0;
        alu_result = 32'h0;
        pc_plus4   = 32'h0000_1004;
        lui_pc     = 32'hABCD_E000;
        load_valid = 1'b0;
        load_data  = 32'h0;
        #12;
        check("rst.we",       64'(rf_we),    64'd0);
        check("rst.waddr",    64'(rf_waddr), 64'd0);
        check("rst.wdata",    64'(rf_wdata), 64'd0);
        check("rst.busy",     64'(wb_busy),  64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
`ifdef WB_RETIRE_CNT_EN
        check("rst.retire", retire_count, 64'd0);
`endif
        rst = 1'b1;
        tick();

        // ALU op to x5
        issue(2'b00, 3'b000, 1'b1, 5'd5, 32'h0000_1234);
        tick();
        check_write("alu", 5'd5, 32'h0000_1234);
        in_valid = 1'b0;
        tick();
        check("alu.idle_we", 64'(rf_we), 64'd0);

        // stray load_valid in IDLE is ignored
        load_valid = 1'b1;
        load_data  = 32'hDEAD_BEEF;
        tick();
        load_valid = 1'b0;
        check("stray.we",   64'(rf_we),   64'd0);
        check("stray.busy", 64'(wb_busy), 64'd0);

        // LB offset 3, response three cycles after accept
        issue(2'b01, 3'b000, 1'b1, 5'd7, 32'h0000_0103);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("lb.busy",  64'(wb_busy),  64'd1);
            check("lb.ready", 64'(in_ready), 64'd0);
            check("lb.we",    64'(rf_we),    64'd0);
            tick();
        end
        check("lb.busy3", 64'(wb_busy), 64'd1);
        load_valid = 1'b1;
        load_data  = 32'h80FF_FFFF;
        tick();
        load_valid = 1'b0;
        check_write("lb", 5'd7, 32'hFFFF_FF80);
        check("lb.busy_done", 64'(wb_busy), 64'd0);

        // LHU offset 2 with response in the accept cycle: written two cycles later
        issue(2'b01, 3'b101, 1'b1, 5'd8, 32'h0000_0002);
        load_valid = 1'b1;
        load_data  = 32'hBEEF_0000;
        tick();
        in_valid   = 1'b0;
        load_valid = 1'b0;
        check("lhu.busy", 64'(wb_busy), 64'd1);
        check("lhu.we0",  64'(rf_we),   64'd0);
        tick();
        check_write("lhu", 5'd8, 32'h0000_BEEF);

        // LH same data, response one cycle after accept
        issue(2'b01, 3'b001, 1'b1, 5'd9, 32'h0000_0002);
        tick();
        in_valid   = 1'b0;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        check_write("lh", 5'd9, 32'hFFFF_BEEF);

        // LBU offset 1 and undefined code 111 (zero-extended word)
        issue(2'b01, 3'b100, 1'b1, 5'd10, 32'h0000_0001);
        load_valid = 1'b1;
        load_data  = 32'h1234_D678;
        tick();
        in_valid   = 1'b0;
        load_valid = 1'b0;
        tick();
        check_write("lbu", 5'd10, 32'h0000_00D6);
        issue(2'b01, 3'b111, 1'b1, 5'd11, 32'h0000_0000);
        load_valid = 1'b1;
        load_data  = 32'h8765_4321;
        tick();
        in_valid   = 1'b0;
        load_valid = 1'b0;
        tick();
        check_write("ld_undef", 5'd11, 32'h8765_4321);

        // Back-to-back: ALU, PC+4, LUI with in_valid held, then rd=0
        issue(2'b00, 3'b000, 1'b1, 5'd1, 32'h0000_0011);
        tick();
        check_write("b2b0", 5'd1, 32'h0000_0011);
        issue(2'b10, 3'b000, 1'b1, 5'd2, 32'h0000_0022);
        tick();
        check_write("b2b1", 5'd2, 32'h0000_1004);
        issue(2'b11, 3'b000, 1'b1, 5'd3, 32'h0000_0033);
        tick();
        check_write("b2b2", 5'd3, 32'hABCD_E000);
        issue(2'b00, 3'b000, 1'b1, 5'd0, 32'h0000_0044);
        tick();
        in_valid = 1'b0;
        check("x0.we", 64'(rf_we), 64'd0);
        tick();
        check("x0.idle_we", 64'(rf_we), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        check("retire.total", retire_count, 64'd10);
`endif

        // Reset while waiting for a load discards it
        issue(2'b01, 3'b010, 1'b1, 5'd12, 32'h0000_0000);
        tick();
        in_valid = 1'b0;
        check("rstw.busy", 64'(wb_busy), 64'd1);
        rst = 1'b0;
        #1;
        check("rstw.async_busy",  64'(wb_busy),  64'd0);
        check("rstw.async_ready", 64'(in_ready), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        load_valid = 1'b1;
        load_data  = 32'h5555_AAAA;
        tick();
        load_valid = 1'b0;
        check("rstw.we",   64'(rf_we),    64'd0);
        check("rstw.busy", 64'(wb_busy),  64'd0);
        check("rstw.idle", 64'(in_ready), 64'd1);
        tick();
        check("rstw.we2", 64'(rf_we), 64'd0);
`ifdef WB_RETIRE_CNT_EN
        check("rstw.retire", retire_count, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 or 64.
REQ-002 Parameter RF_AW, default 5, register-file address width.
REQ-003 Ports, name / direction / width / meaning:
- clk  in  1  the single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  MEM-side instruction valid.
- in_ready  out  1  stage can accept.
- result_src  in  2  result select: 00 ALU, 01 load, 10 PC+4, 11 LUI/AUIPC.
- load_sel  in  3  RISC-V funct3 load type.
- reg_write  in  1  instruction writes rd.
- rd_addr  in  RF_AW  destination register.
- alu_result, pc_plus4, lui_pc  in  XLEN  result candidates; alu_result also gives the load byte address.
- load_valid  in  1  data-memory response strobe.
- load_data  in  XLEN  raw memory word.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  RF_AW  write address.
- rf_wdata  out  XLEN  write data.
- wb_busy  out  1  high while waiting on a load.

Function
REQ-004 FSM states: IDLE, WAIT_LOAD, WRITE.
REQ-005 in_ready is 1 in IDLE and WRITE, and 0 in WAIT_LOAD.
REQ-006 Accept occurs when in_valid and in_ready are both 1; all inputs except load_valid/load_data are captured on accept.
REQ-007 Accepting a non-load goes to WRITE.
- rf_we is asserted exactly one cycle after accept.
- rf_wdata carries the selected source: ALU, PC+4 or LUI/AUIPC.
REQ-008 Accepting a load (result_src=01) goes to WAIT_LOAD; wb_busy=1 there.
REQ-009 In WAIT_LOAD, a load_valid goes to WRITE; rf_we is asserted the following cycle with the extended data.
REQ-010 A load_valid in the accept cycle itself is honoured, giving a minimum load latency of 2 cycles.
REQ-011 In WRITE, a new accept is allowed in the same cycle (back-to-back, one instruction per cycle); otherwise the FSM returns to IDLE.
REQ-012 Load extension uses byte offset = alu_result[2:0] for XLEN=64, or alu_result[1:0] for XLEN=32:
- LB 000 and LBU 100 take the byte at the offset.
- LH 001 and LHU 101 take the halfword at offset[2:1].
- LW 010 takes the word; LWU 110 takes the word zero-extended (XLEN=64 only).
- LD 011 takes the doubleword (XLEN=64 only).
- Signed forms sign-extend to XLEN; unsigned forms zero-extend.
REQ-013 Undefined load_sel codes, and the XLEN-64-only codes when XLEN=32, produce a zero-extended word.
REQ-014 Misaligned offsets are not checked; lanes are selected purely by the offset bits.
REQ-015 rf_we = captured reg_write AND (rd_addr != 0) AND write pulse; x0 is never written.
REQ-016 rf_we is high for exactly one cycle per retired instruction.
REQ-017 rf_waddr/rf_wdata are valid only while rf_we is high.
REQ-018 load_valid outside WAIT_LOAD and outside load-accept cycles is ignored.

Reset
REQ-019 rst low asynchronously forces:
- state IDLE.
- rf_we=0, rf_waddr=0, rf_wdata=0.
- wb_busy=0, in_ready=1 (combinational from IDLE).
REQ-020 Reset during WAIT_LOAD discards the pending load; a later load_valid does not write.

Configuration
REQ-021 Macro WB_RETIRE_CNT_EN:
- Defined: the block adds output retire_count (64 bits), reset to 0, incremented on every rf_we pulse plus every retired instruction whose write was suppressed, wrapping at 2^64.
- Undefined: the port and counter do not exist.

Verification
REQ-022 ALU op, reg_write=1, rd=5, alu_result=0x1234 -> next cycle rf_we=1, waddr=5, wdata=0x1234.
REQ-023 LB, alu_result=0x...3, load_valid 3 cycles later with data 0x80FF_FFFF -> wdata=0xFFFF_FF80, wb_busy high until load_valid, in_ready low meanwhile.
REQ-024 LHU offset 2, data 0xBEEF_0000 -> wdata=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-025 Three back-to-back ALU ops with in_valid held 1 -> three consecutive rf_we pulses, no bubble; rd=0 op -> rf_we stays 0, and with WB_RETIRE_CNT_EN retire_count still increments.
REQ-026 Assert rst in WAIT_LOAD, release, then pulse load_valid -> no rf_we, state IDLE, retire_count=0.
